// File: rtl/spi_cmd_slave.sv
// SPI mode-0 target that turns host frames into register-bus reads and writes.
// spi_clk is oversampled in the clk domain, so it must run at clk/4 or slower.
module spi_cmd_slave #(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rw,
  output logic [1:0]        txn_width,
  output logic              reg_addr_v,
  input  logic [REG_W-1:0]  reg_data_i,
  input  logic              reg_data_i_dv,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_dv
);
  localparam int HDR_W = 3 + ADDR_W;
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {IDLE, HDR, WDATA, RWAIT, RDATA, DONE} state_e;

  state_e            state_q;
  logic              sclk_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [HDR_W-2:0]  hdr_q;
  logic [REG_W-1:0]  wr_q;
  logic [REG_W-1:0]  rd_q;
  logic              miso_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [1:0]        width_q;
  logic              addr_v_q;
  logic [REG_W-1:0]  data_o_q;
  logic              data_o_dv_q;

  logic              rise;
  logic              fall;
  logic [HDR_W-1:0]  hdr_d;
  logic [REG_W-1:0]  wr_d;
  logic [REG_W-1:0]  rd_load_d;
  logic [CNT_W-1:0]  last_bit_d;
  logic [1:0]        width_d;

  assign rise  = spi_clk & ~sclk_q;
  assign fall  = ~spi_clk & sclk_q;
  assign hdr_d = {hdr_q, spi_mosi};
  assign wr_d  = {wr_q[REG_W-2:0], spi_mosi};
  // Width code 11 behaves exactly like 10 (32-bit transfer).
  assign width_d = (hdr_d[HDR_W-2:HDR_W-3] == 2'b11) ? 2'b10 : hdr_d[HDR_W-2:HDR_W-3];

  always_comb begin
    last_bit_d = CNT_W'(31);
    rd_load_d  = reg_data_i;
    case (width_q)
      2'b00: begin
        last_bit_d = CNT_W'(7);
        rd_load_d  = {reg_data_i[7:0], {(REG_W-8){1'b0}}};
      end
      2'b01: begin
        last_bit_d = CNT_W'(15);
        rd_load_d  = {reg_data_i[15:0], {(REG_W-16){1'b0}}};
      end
      default: begin
        last_bit_d = CNT_W'(31);
        rd_load_d  = reg_data_i;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_q      <= 1'b0;
      cnt_q       <= '0;
      hdr_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      miso_q      <= 1'b0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      width_q     <= 2'b00;
      addr_v_q    <= 1'b0;
      data_o_q    <= '0;
      data_o_dv_q <= 1'b0;
    end else begin
      sclk_q      <= spi_clk;
      data_o_dv_q <= 1'b0;
      if (spi_cs_n) begin
        // Deselect abandons the frame; header fields and write data stay put.
        state_q  <= IDLE;
        addr_v_q <= 1'b0;
        miso_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= HDR;
            cnt_q   <= '0;
          end
          HDR: begin
            if (rise) begin
              hdr_q <= hdr_d[HDR_W-2:0];
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == CNT_W'(HDR_W-1)) begin
                rw_q    <= hdr_d[HDR_W-1];
                width_q <= width_d;
                addr_q  <= hdr_d[ADDR_W-1:0];
                cnt_q   <= '0;
                if (hdr_d[HDR_W-1]) begin
                  state_q <= WDATA;
                  wr_q    <= '0;
                end else begin
                  state_q  <= RWAIT;
                  addr_v_q <= 1'b1;
                  rd_q     <= '0;
                end
              end
            end
          end
          WDATA: begin
            if (rise) begin
              wr_q  <= wr_d;
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == last_bit_d) begin
                data_o_q    <= wr_d;
                data_o_dv_q <= 1'b1;
                state_q     <= DONE;
              end
            end
          end
          RWAIT: begin
            if (addr_v_q && reg_data_i_dv) begin
              rd_q     <= rd_load_d;
              addr_v_q <= 1'b0;
            end
            // Eight dummy rises give the peripheral time to answer.
            if (rise) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == CNT_W'(7)) begin
                state_q  <= RDATA;
                cnt_q    <= '0;
                addr_v_q <= 1'b0;
              end
            end
          end
          RDATA: begin
            if (fall) begin
              miso_q <= rd_q[REG_W-1];
              rd_q   <= {rd_q[REG_W-2:0], 1'b0};
            end
            if (rise) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == last_bit_d) begin
                state_q <= DONE;
              end
            end
          end
          DONE: begin
            if (fall) begin
              miso_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi_miso      = miso_q;
  assign reg_addr      = addr_q;
  assign reg_rw        = rw_q;
  assign txn_width     = width_q;
  assign reg_addr_v    = addr_v_q;
  assign reg_data_o    = data_o_q;
  assign reg_data_o_dv = data_o_dv_q;
endmodule

// File: doc/spi_cmd_slave.md
Name: spi_cmd_slave

Overview:
- SPI target that turns host SPI frames into register-bus transactions for the peripheral: address, write data, write strobe, read request, read-data return.
- Sits directly upstream of the peripheral, between the 2-stage input synchronizers and the peripheral's address/data/read/write pins.
- All SPI inputs arrive already synchronized to clk. The block oversamples spi_clk in the clk domain; spi_clk must stay at or below clk/4.

Parameters:
- ADDR_W, 6, register address width.
- REG_W, 32, register data width. Must be 32.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- spi_cs_n  in  1  synchronized chip select, active low.
- spi_clk  in  1  synchronized SPI clock. Mode 0: CPOL=0, CPHA=0.
- spi_mosi  in  1  synchronized host data.
- spi_miso  out  1  target data. Changes only after falling spi_clk edges.
- reg_addr  out  ADDR_W  register address from the header.
- reg_rw  out  1  1=write, 0=read.
- txn_width  out  2  transaction width: 00=8b, 01=16b, 10=32b.
- reg_addr_v  out  1  read request. Held until the read data is captured.
- reg_data_i  in  REG_W  read data from the peripheral.
- reg_data_i_dv  in  1  read data valid (data_ready).
- reg_data_o  out  REG_W  write data, right-aligned.
- reg_data_o_dv  out  1  write strobe, one cycle.

Behaviour:
- Reset is asynchronous and active-low. All outputs reset to 0, the FSM resets to IDLE, and the edge-detect register resets to 0.
- Edge detect: a registered copy of spi_clk.
  - rise = spi_clk & !prev; fall = !spi_clk & prev.
  - mosi is sampled on the clk edge ending the rise cycle.
- Frame layout, MSB first:
  - header: rw (1 bit), then txn_width (2 bits), then address (ADDR_W bits); 9 bits at default.
  - then the data phase.
- Data length N: 8, 16 or 32 bits for width 00/01/10. Width 11 is treated as 10 (32 bits) and txn_width is output as 10.
- FSM states:
  - IDLE -> HDR when spi_cs_n is low. Bit counter cleared.
  - HDR: shift in header bits. After the last header bit is captured:
    - reg_addr, reg_rw and txn_width update the next cycle.
    - write: -> WDATA.
    - read: -> RWAIT, and reg_addr_v=1 the same next cycle.
  - WDATA: shift N bits into a shift register. After bit N is captured:
    - next cycle: reg_data_o = the N bits zero-extended, reg_data_o_dv=1 for exactly one cycle.
    - -> DONE.
  - RWAIT: 8 dummy spi_clk rises; spi_miso=0 throughout.
    - The first cycle with reg_addr_v & reg_data_i_dv loads the read shift register with reg_data_i[N-1:0], left-aligned, and clears reg_addr_v the next cycle.
    - After the 8th dummy rise: -> RDATA.
    - If no data has been captured by then, the shift register holds 0 and reg_addr_v is dropped. The host reads zeros.
  - RDATA: on each fall, spi_miso = next shift-register MSB. The first data bit is driven on the fall that follows the 8th dummy rise. After N rises: -> DONE.
  - DONE: further spi_clk edges are ignored; spi_miso=0.
- Any cycle with spi_cs_n high aborts the frame:
  - FSM -> IDLE next cycle; reg_addr_v cleared; spi_miso=0.
  - No reg_data_o_dv is issued for a partial write.
  - reg_addr, reg_rw, txn_width and reg_data_o keep their last values.
- Frame held outputs: reg_addr, reg_rw and txn_width stay stable from header completion until the next header completes.
- Clock edges while spi_cs_n is high are ignored.
- If reg_data_i_dv arrives while reg_addr_v=0, it is ignored.

Test Plan:
- Write 32b to addr 0x05, header 1_10_000101 then data 0xDEADBEEF -> one cycle of reg_data_o_dv with reg_data_o=0xDEADBEEF, reg_addr=5, reg_rw=1, txn_width=10; reg_addr_v never asserts.
- Write 8b to addr 0x3F with data 0xA5 -> reg_data_o=0x000000A5, txn_width=00, exactly one strobe.
- Read 16b from addr 0x02, peripheral answers reg_data_i_dv 3 cycles after reg_addr_v with 0x12345678 -> reg_addr_v high for 4 cycles; MISO carries 8 zeros then 0x5678 MSB first.
- Read 32b with reg_data_i_dv never asserted -> reg_addr_v drops after the dummy byte; MISO returns 0x00000000; no hang, and the next frame works.
- Write aborted by spi_cs_n high after 20 data bits -> no reg_data_o_dv; FSM in IDLE; a following complete 8b write to addr 1 with 0x3C strobes correctly.
- rst_n asserted mid-read-data -> all outputs 0 immediately (asynchronously, without a clk edge); after release, a fresh 8b read of 0x81 returns 0x81.
